// File: rtl/platform_pio_pkg.sv
// Definitions shared by the platform PIO blocks: register word addresses
// and the blink half-period field width.
package platform_pio_pkg;

  localparam int HALF_PERIOD_W = 16;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_BLINK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD  = 3'd2;
  localparam logic [2:0] ADDR_TICKCNT = 3'd3;
  localparam logic [2:0] ADDR_SET     = 3'd4;
  localparam logic [2:0] ADDR_CLR     = 3'd5;
  localparam logic [2:0] ADDR_PHASE   = 3'd6;

endpackage

// File: rtl/platform_led_if.sv
// Avalon-MM slave bus bundle for the platform PIO blocks.
// Signals:
//   address    - register word address
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - registered read data, one cycle after the address
interface platform_led_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/platform_led_blinker.sv
// Blink engine: a clock prescaler producing a tick every PRESCALE cycles and
// a tick counter that toggles the blink phase every i_half_period ticks.
// Ports:
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   i_half_period    - ticks per half blink period; 0 stops and clears the engine
//   i_restart        - one-cycle pulse clearing prescaler, tick count and phase
//   o_phase          - current blink phase (1 = blinking LEDs dark)
//   o_tick_cnt       - tick count within the current half period
module platform_led_blinker
  import platform_pio_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [HALF_PERIOD_W-1:0] i_half_period,
  input  logic                     i_restart,
  output logic                     o_phase,
  output logic [HALF_PERIOD_W-1:0] o_tick_cnt
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]          r_prescaler;
  logic [HALF_PERIOD_W-1:0] r_tick_cnt;
  logic                     r_phase;

  logic w_run;
  logic w_tick;
  logic w_last_tick;

  assign w_run       = (i_half_period != '0);
  assign w_tick      = (r_prescaler == PS_LAST);
  assign w_last_tick = (r_tick_cnt == (i_half_period - HALF_PERIOD_W'(1)));

  // Restart has priority over a coincident tick so a new period always
  // begins from a clean, unblinked state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prescaler <= '0;
      r_tick_cnt  <= '0;
      r_phase     <= 1'b0;
    end else if (i_restart || !w_run) begin
      r_prescaler <= '0;
      r_tick_cnt  <= '0;
      r_phase     <= 1'b0;
    end else if (w_tick) begin
      r_prescaler <= '0;
      if (w_last_tick) begin
        r_tick_cnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_tick_cnt <= r_tick_cnt + HALF_PERIOD_W'(1);
      end
    end else begin
      r_prescaler <= r_prescaler + PS_W'(1);
    end
  end

  assign o_phase    = r_phase;
  assign o_tick_cnt = r_tick_cnt;

endmodule

// File: rtl/platform_led.sv
// LED output PIO on the platform slave interconnect. A CPU-written data
// register drives the LEDs, with atomic set/clear strobes and a hardware
// blink engine that darkens masked LEDs while the blink phase is high.
// Ports:
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   bus_if           - Avalon-MM slave (registered readdata, no wait states)
//   o_out_port       - LED drive, WIDTH bits
module platform_led
  import platform_pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PRESCALE    = 50000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  platform_led_if.slave     bus_if,
  output logic [WIDTH-1:0]  o_out_port
);

  logic [WIDTH-1:0]         r_data;
  logic [WIDTH-1:0]         r_blink_mask;
  logic [HALF_PERIOD_W-1:0] r_half_period;
  logic [31:0]              r_readdata;

  logic                     w_wr;
  logic                     w_restart;
  logic [WIDTH-1:0]         w_wdata;
  logic [31:0]              w_rd_mux;
  logic                     w_phase;
  logic [HALF_PERIOD_W-1:0] w_tick_cnt;
  logic                     w_unused_wdata;

  assign w_wr      = bus_if.chipselect & ~bus_if.write_n;
  assign w_restart = w_wr && (bus_if.address == ADDR_PERIOD);
  assign w_wdata   = bus_if.writedata[WIDTH-1:0];

  // Write data bits above the register widths are intentionally ignored.
  assign w_unused_wdata = ^bus_if.writedata;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data        <= RESET_VALUE[WIDTH-1:0];
      r_blink_mask  <= '0;
      r_half_period <= '0;
    end else if (w_wr) begin
      case (bus_if.address)
        ADDR_DATA:   r_data        <= w_wdata;
        ADDR_BLINK:  r_blink_mask  <= w_wdata;
        ADDR_PERIOD: r_half_period <= bus_if.writedata[HALF_PERIOD_W-1:0];
        ADDR_SET:    r_data        <= r_data | w_wdata;
        ADDR_CLR:    r_data        <= r_data & ~w_wdata;
        default:     ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus_if.address)
      ADDR_DATA:    w_rd_mux = 32'(r_data);
      ADDR_BLINK:   w_rd_mux = 32'(r_blink_mask);
      ADDR_PERIOD:  w_rd_mux = 32'(r_half_period);
      ADDR_TICKCNT: w_rd_mux = 32'(w_tick_cnt);
      ADDR_PHASE:   w_rd_mux = 32'(w_phase);
      default:      w_rd_mux = '0;
    endcase
  end

  // Read data is captured every cycle regardless of chipselect.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus_if.readdata = r_readdata;

  platform_led_blinker #(
    .PRESCALE (PRESCALE)
  ) u_blinker (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_half_period (r_half_period),
    .i_restart     (w_restart),
    .o_phase       (w_phase),
    .o_tick_cnt    (w_tick_cnt)
  );

  assign o_out_port = r_data & ~(r_blink_mask & {WIDTH{w_phase}});

endmodule

// File: tb/tb_platform_led.sv
module tb_platform_led;
  import platform_pio_pkg::*;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] out_port;

  platform_led_if bus_if();

  platform_led #(
    .WIDTH       (8),
    .RESET_VALUE (32'h0000_00A5),
    .PRESCALE    (4)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .bus_if     (bus_if),
    .o_out_port (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_rd;
    logic [31:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t out_q[$];
  exp_t imm_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  bit req_rd  = 1'b0;
  bit req_out = 1'b0;
  bit vld_rd  = 1'b0;
  bit vld_out = 1'b0;

  event ev_imm;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response pipeline: a check requested in a bus cycle becomes due after
  // that cycle's clock edge and is evaluated on the following falling edge.
  always @(posedge clk) begin
    vld_rd  <= req_rd;
    vld_out <= req_out;
  end

  always @(negedge clk) begin : mon_pipe
    exp_t e;
    if (vld_rd) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL rd_q_empty: readdata %h with no expectation", bus_if.readdata);
      end else begin
        e = rd_q.pop_front();
        compare(e.name, bus_if.readdata, e.exp);
      end
    end
    if (vld_out) begin
      if (out_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL out_q_empty: out_port %h with no expectation", out_port);
      end else begin
        e = out_q.pop_front();
        compare(e.name, 32'(out_port), e.exp);
      end
    end
  end

  always begin : mon_imm
    exp_t e;
    @(ev_imm);
    while (imm_q.size() > 0) begin
      e = imm_q.pop_front();
      compare(e.name, e.is_rd ? bus_if.readdata : 32'(out_port), e.exp);
    end
  end

  task automatic bus_cycle(input string name, input logic cs, input logic wn,
                           input logic [2:0] addr, input logic [31:0] wd,
                           input bit chk_rd, input logic [31:0] rd_exp,
                           input bit chk_out, input logic [7:0] out_exp);
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.address    = addr;
    bus_if.writedata  = wd;
    req_rd  = chk_rd;
    req_out = chk_out;
    if (chk_rd)  rd_q.push_back('{{name, "_rd"}, 1'b1, rd_exp});
    if (chk_out) out_q.push_back('{{name, "_out"}, 1'b0, 32'(out_exp)});
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string name, input logic [2:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd_exp, input logic [7:0] out_exp);
    bus_cycle(name, 1'b1, 1'b0, addr, wd, 1'b1, rd_exp, 1'b1, out_exp);
  endtask

  task automatic do_read(input string name, input logic [2:0] addr,
                         input logic [31:0] rd_exp, input logic [7:0] out_exp);
    bus_cycle(name, 1'b1, 1'b1, addr, 32'h0, 1'b1, rd_exp, 1'b1, out_exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      bus_cycle("idle", 1'b0, 1'b1, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic check_imm(input string name, input bit is_rd, input logic [31:0] exp);
    imm_q.push_back('{name, is_rd, exp});
    -> ev_imm;
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors expected completion", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 3'd0;
    bus_if.writedata  = 32'h0;

    #1 reset_n = 1'b0;
    #1;
    check_imm("reset_readdata", 1'b1, 32'h0);
    check_imm("reset_out", 1'b0, 32'hA5);
    idle(2);
    check_imm("reset_held_readdata", 1'b1, 32'h0);
    reset_n = 1'b1;

    // Register access: write, set, clear, ignored addresses, no chipselect.
    do_read ("rd_reset_data", ADDR_DATA, 32'hA5, 8'hA5);
    do_write("wr_data",       ADDR_DATA, 32'h0F, 32'hA5, 8'h0F);
    do_write("wr_set",        ADDR_SET,  32'hF0, 32'h00, 8'hFF);
    do_write("wr_clr",        ADDR_CLR,  32'h3C, 32'h00, 8'hC3);
    do_write("wr_addr3_ign",  3'd3,      32'h55, 32'h00, 8'hC3);
    do_write("wr_addr7_ign",  3'd7,      32'hFF, 32'h00, 8'hC3);
    bus_cycle("wr_no_cs", 1'b0, 1'b0, ADDR_DATA, 32'h0, 1'b1, 32'hC3, 1'b1, 8'hC3);
    do_read ("rd_data",       ADDR_DATA, 32'hC3, 8'hC3);

    // Blink with half_period=3, PRESCALE=4: phase toggles every 12 clocks.
    do_write("wr_data_ff",    ADDR_DATA,   32'hFF, 32'hC3, 8'hFF);
    do_write("wr_mask",       ADDR_BLINK,  32'h01, 32'h00, 8'hFF);
    do_write("wr_hp3",        ADDR_PERIOD, 32'h03, 32'h00, 8'hFF);
    for (int k = 0; k < 20; k++)
      do_read($sformatf("blink_%0d", k), ADDR_TICKCNT, 32'((k / 4) % 3),
              (((k + 1) / 12) % 2) ? 8'hFE : 8'hFF);

    // Disable while phase is high: engine freezes at phase 0.
    do_write("wr_hp0", ADDR_PERIOD, 32'h0, 32'h3, 8'hFF);
    for (int k = 0; k < 100; k++)
      do_read("frozen", ADDR_PHASE, 32'h0, 8'hFF);

    // half_period write on the exact toggle edge: the write wins.
    do_write("wr_hp2", ADDR_PERIOD, 32'h2, 32'h0, 8'hFF);
    idle(6);
    do_read ("tick_pre",      ADDR_TICKCNT, 32'h1, 8'hFF);
    do_write("wr_hp_on_tick", ADDR_PERIOD,  32'h2, 32'h2, 8'hFF);
    do_read ("tick_after",    ADDR_TICKCNT, 32'h0, 8'hFF);
    do_read ("phase_after",   ADDR_PHASE,   32'h0, 8'hFF);
    idle(5);
    do_read ("phase_toggle",  ADDR_PHASE,   32'h0, 8'hFE);

    // Clearing the mask while phase is high restores the LED immediately.
    do_write("wr_mask_clr",     ADDR_BLINK, 32'h0, 32'h1, 8'hFF);
    do_read ("phase_hi",        ADDR_PHASE, 32'h1, 8'hFF);
    do_write("wr_mask_set",     ADDR_BLINK, 32'h1, 32'h0, 8'hFE);
    do_read ("rd_data_pre_rst", ADDR_DATA,  32'hFF, 8'hFE);
    idle(1);

    // Asynchronous reset mid-blink, between clock edges.
    reset_n = 1'b0;
    #1;
    check_imm("midrst_readdata", 1'b1, 32'h0);
    check_imm("midrst_out", 1'b0, 32'hA5);
    idle(2);
    check_imm("midrst_held_readdata", 1'b1, 32'h0);
    reset_n = 1'b1;

    for (int k = 0; k < 30; k++)
      do_read("idle_after_rst", ADDR_PHASE, 32'h0, 8'hA5);
    do_read("hp_after_rst",    ADDR_PERIOD,  32'h0, 8'hA5);
    do_read("tick_after_rst",  ADDR_TICKCNT, 32'h0, 8'hA5);
    do_read("mask_after_rst",  ADDR_BLINK,   32'h0, 8'hA5);
    do_read("rd4_zero",        ADDR_SET,     32'h0, 8'hA5);
    idle(3);

    if (rd_q.size() != 0 || out_q.size() != 0 || imm_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL pending: got %0d unchecked expectations expected 0",
               rd_q.size() + out_q.size() + imm_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
